// File: rtl/rns_crt_decode_pkg.sv
// -----------------------------------------------------------------------------
// rns_crt_decode_pkg
// Shared constants and types for the RNS-to-binary (CRT) decoder.
//
// Contents:
//   Q_BASIS      : q-basis moduli q_j
//   CRT_Q        : Q = product of q_j
//   CRT_Q_HALF   : floor(Q/2), centered-lift threshold
//   CRT_QHAT[j]  : Q / q_j
//   CRT_Y[j]     : (Q / q_j)^-1 mod q_j
//   res_vec_t    : residue vector at the default limb width
//   crt_result_t : OUT_W+1 bit two's-complement result at the default width
//   crt_state_e  : decoder FSM states
//
// All CRT constants are generated offline from the basis and stored here as
// literals; the RTL never derives them. Regenerate together with Q_BASIS.
// -----------------------------------------------------------------------------
package rns_crt_decode_pkg;

    localparam int Q_BASIS_LEN = 3;
    localparam int LIMB_W_DEF  = 32;
    localparam int CONST_W     = 128;

    typedef logic [CONST_W-1:0] crt_const_t;

    localparam crt_const_t Q_BASIS  [Q_BASIS_LEN] = '{128'd3, 128'd5, 128'd7};
    localparam crt_const_t CRT_QHAT [Q_BASIS_LEN] = '{128'd35, 128'd21, 128'd15};
    localparam crt_const_t CRT_Y    [Q_BASIS_LEN] = '{128'd2, 128'd1, 128'd1};
    localparam crt_const_t CRT_Q      = 128'd105;
    localparam crt_const_t CRT_Q_HALF = 128'd52;

    typedef logic [Q_BASIS_LEN*LIMB_W_DEF-1:0] res_vec_t;
    typedef logic [Q_BASIS_LEN*LIMB_W_DEF:0]   crt_result_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } crt_state_e;

endpackage

// File: rtl/rns_crt_decode_modmul_reduce.sv
// -----------------------------------------------------------------------------
// modmul_reduce
// Combinational modular multiply: res = (a * b) mod m, LIMB_W-bit operands.
//
// Ports:
//   a, b : operands (a may exceed m; it is reduced along with the product)
//   m    : modulus, non-zero
//   res  : (a*b) mod m
// -----------------------------------------------------------------------------
module modmul_reduce
    import rns_crt_decode_pkg::*;
#(
    parameter int LIMB_W = 32
) (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic [LIMB_W-1:0] m,
    output logic [LIMB_W-1:0] res
);

    logic [2*LIMB_W-1:0] prod;

    assign prod = (2*LIMB_W)'(a) * (2*LIMB_W)'(b);
    // The remainder is below m, so truncating to LIMB_W is lossless.
    assign res  = LIMB_W'(prod % (2*LIMB_W)'(m));

endmodule

// File: rtl/rns_crt_decode.sv
// -----------------------------------------------------------------------------
// rns_crt_decode
// Sequential RNS-to-binary decoder for one polynomial slot. Accepts a q-basis
// residue vector and reconstructs x = sum_j ((r_j*Y_j) mod q_j)*QH_j mod Q,
// one limb per cycle.
//
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : residue vector present
//   in_ready  : block can accept a vector (IDLE only)
//   in_res    : residues, limb 0 in the low bits (sampled at acceptance only)
//   out_valid : result present
//   out_ready : consumer accepts the result
//   out_data  : reconstructed value, OUT_W+1 bit two's complement
//
// Build option: define CRT_SIGNED_EN for a centered-lift output
// (x > floor(Q/2) gives x - Q). Undefined: out_data = {1'b0, x}.
// -----------------------------------------------------------------------------
module rns_crt_decode
    import rns_crt_decode_pkg::*;
#(
    parameter int N_LIMBS = Q_BASIS_LEN,
    parameter int LIMB_W  = 32,
    parameter int OUT_W   = N_LIMBS * LIMB_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_LIMBS*LIMB_W-1:0] in_res,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W:0]            out_data
);

    localparam int             J_W    = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
    localparam logic [J_W-1:0] J_LAST = J_W'(N_LIMBS - 1);
    localparam logic [OUT_W:0] Q_EXT  = (OUT_W+1)'(CRT_Q);

    crt_state_e state, state_next;

    logic [N_LIMBS*LIMB_W-1:0] res_q;
    logic [OUT_W:0]            acc;
    logic [J_W-1:0]            j;

    logic                      accept;
    logic                      last;
    logic [LIMB_W-1:0]         r_j;
    logic [LIMB_W-1:0]         q_j;
    logic [LIMB_W-1:0]         y_j;
    logic [OUT_W-1:0]          qh_j;
    logic [LIMB_W-1:0]         t;
    logic [OUT_W+LIMB_W-1:0]   tq;
    logic [OUT_W:0]            s;
    logic [OUT_W:0]            acc_next;
    logic [OUT_W:0]            result_next;

    assign accept = in_valid && in_ready;
    assign last   = (state == ST_ACCUM) && (j == J_LAST);

    // Limb selector: picks the current residue and its per-limb constants.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        r_j  = '0;
        q_j  = '0;
        y_j  = '0;
        qh_j = '0;
        for (int k = 0; k < N_LIMBS; k++) begin
            if (j == J_W'(k)) begin
                r_j  = res_q[k*LIMB_W +: LIMB_W];
                q_j  = LIMB_W'(Q_BASIS[k]);
                y_j  = LIMB_W'(CRT_Y[k]);
                qh_j = OUT_W'(CRT_QHAT[k]);
            end
        end
    end

    // Out-of-range residues are reduced here together with the product.
    modmul_reduce #(
        .LIMB_W (LIMB_W)
    ) u_modmul_reduce (
        .a   (r_j),
        .b   (y_j),
        .m   (q_j),
        .res (t)
    );

    // t < q_j, so t*QH_j < Q fits in OUT_W bits; acc < Q keeps s < 2Q and a
    // single conditional subtract brings it back into [0, Q).
    assign tq       = (OUT_W+LIMB_W)'(t) * (OUT_W+LIMB_W)'(qh_j);
    assign s        = acc + (OUT_W+1)'(tq);
    assign acc_next = (s >= Q_EXT) ? (s - Q_EXT) : s;

`ifdef CRT_SIGNED_EN
    // Centered lift folded into the DONE register load.
    assign result_next = (acc_next > (OUT_W+1)'(CRT_Q_HALF)) ? (acc_next - Q_EXT)
                                                              : acc_next;
`else
    // acc_next < Q, so its top bit is already the zero sign bit.
    assign result_next = acc_next;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (accept)    state_next = ST_ACCUM;
            ST_ACCUM: if (last)      state_next = ST_DONE;
            ST_DONE:  if (out_ready) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath is reset as well so a reset mid-operation leaves
        // no stale partial sum and out_data comes up at zero.
        if (!rst_n) begin
            res_q    <= '0;
            acc      <= '0;
            j        <= '0;
            out_data <= '0;
        end else if (accept) begin
            res_q <= in_res;
            acc   <= '0;
            j     <= '0;
        end else if (state == ST_ACCUM) begin
            acc <= acc_next;
            if (last) begin
                j        <= '0;
                out_data <= result_next;
            end else begin
                j <= j + J_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rns_crt_decode.sv
// -----------------------------------------------------------------------------
// tb_rns_crt_decode
// Self-checking bench for rns_crt_decode with q-basis {3,5,7}, LIMB_W=8.
// Expected values come from a brute-force CRT search over [0, Q).
// -----------------------------------------------------------------------------
module tb_rns_crt_decode;

    localparam int N_LIMBS = 3;
    localparam int LIMB_W  = 8;
    localparam int OUT_W   = N_LIMBS * LIMB_W;
    localparam int Q       = 105;

    logic                      clk;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_LIMBS*LIMB_W-1:0] in_res;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W:0]            out_data;

    int checks;
    int errors;

    rns_crt_decode #(
        .N_LIMBS (N_LIMBS),
        .LIMB_W  (LIMB_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the unique x in [0,Q) congruent to each residue, optionally
    // lifted into (-Q/2, Q/2].
    function automatic logic [OUT_W:0] model(input int r0, input int r1, input int r2);
        int x;
        x = 0;
        for (int c = 0; c < Q; c++) begin
            if ((c % 3 == r0 % 3) && (c % 5 == r1 % 5) && (c % 7 == r2 % 7)) x = c;
        end
`ifdef CRT_SIGNED_EN
        if (x > Q / 2) x = x - Q;
`endif
        return (OUT_W+1)'(x);
    endfunction

    // Drives one vector, checks latency, value and stability while out_ready
    // is held low for 'hold' cycles (with a stray in_valid), then the transfer.
    task automatic send_and_check(input string name, input int r0, input int r1,
                                  input int r2, input int hold);
        logic [OUT_W:0] exp_val;
        int             cyc;
        exp_val   = model(r0, r1, r2);
        in_res    = {8'(r2), 8'(r1), 8'(r0)};
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_res   = 24'($urandom);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_after_accept: got %b want 0", name, in_ready);
        end
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== N_LIMBS) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, N_LIMBS);
        end
        checks++;
        if (out_data !== exp_val) begin
            errors++;
            $display("FAIL %s out_data: got %0d want %0d", name, $signed(out_data), $signed(exp_val));
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_res   = 24'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_val) begin
                errors++;
                $display("FAIL %s hold%0d: got valid=%b ready=%b data=%0d want valid=1 ready=0 data=%0d",
                         name, h, out_valid, in_ready, $signed(out_data), $signed(exp_val));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s transfer: got valid=%b ready=%b want valid=0 ready=1",
                     name, out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_res    = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b data=%0d want 0 1 0",
                     out_valid, in_ready, out_data);
        end
        #21 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        send_and_check("x52",     1, 2, 3, 0);
        send_and_check("x53",     2, 3, 4, 0);
        send_and_check("x104",    2, 4, 6, 0);
        send_and_check("zero",    0, 0, 0, 0);
        send_and_check("oor_x52", 4, 7, 10, 0);
    endtask

    task automatic test_backpressure();
        send_and_check("bp", 2, 3, 4, 5);
        // The stray in_valid during DONE must not have started a new job.
        for (int i = 0; i < N_LIMBS + 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_ignored%0d: got valid=%b ready=%b want valid=0 ready=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        in_res   = {8'd3, 8'd2, 8'd1};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b ready=%b want valid=0 ready=1",
                     out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < N_LIMBS + 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_out%0d: got valid=%b want 0", i, out_valid);
            end
        end
        send_and_check("after_reset", 1, 2, 3, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            send_and_check($sformatf("rnd%0d", n), int'($urandom_range(255)),
                           int'($urandom_range(255)), int'($urandom_range(255)),
                           int'($urandom_range(3)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rns_crt_decode.md
# rns_crt_decode

- Sequential RNS-to-binary decoder for one polynomial slot: the inverse of the per-limb residue reduction used by the modular multiplier.
- Accepts one slot's q-basis residue vector.
- Recombines the residues by Chinese Remainder Theorem (CRT) reconstruction, one limb per cycle.
- Emits the integer value mod Q, where Q = product of q_BASIS.
- Sits at the output of the evaluation datapath, ahead of decoding and host readback.

## Interface
Parameters:
- N_LIMBS, default `q_BASIS_LEN: number of q-basis moduli.
- LIMB_W, default 32: residue and modulus width.
- OUT_W, default N_LIMBS*LIMB_W: width of Q and of the reconstructed magnitude.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  residue vector present.
- in_ready  output  1  block can accept a vector.
- in_res  input  N_LIMBS×LIMB_W  residues r_j, limb 0 in the low bits.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_W+1  reconstructed value, two's complement.

## Operation
- Reconstruction: x = Σ_j ((r_j·Y_j) mod q_j)·QH_j mod Q.
  - QH_j = Q/q_j.
  - Y_j = QH_j⁻¹ mod q_j.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch in_res, clear acc, set limb index j=0, go to ACCUM.
  - ACCUM: each cycle computes t=(r_j·Y_j) mod q_j, then s=acc+t·QH_j.
    - acc ← (s≥Q) ? s−Q : s. Since t·QH_j<Q and acc<Q, one conditional subtract suffices.
    - j increments each cycle. After limb N_LIMBS−1, register out_data from the final acc and go to DONE.
  - DONE: out_valid=1, out_data held stable. On out_ready, go to IDLE.
- Arithmetic widths:
  - r_j·Y_j: 2·LIMB_W bits.
  - t·QH_j: OUT_W+LIMB_W bits.
  - acc: OUT_W+1 bits internally, to hold the pre-subtract sum.
- Out-of-range residues (r_j ≥ q_j) are legal. The mod stage reduces them, so the result equals the value for r_j mod q_j.
- in_res is sampled only at acceptance; later changes have no effect.
- in_valid is ignored outside IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, acc=0, j=0.
- Latency: acceptance at edge E0; limb j is processed at edge E(j+1); out_valid rises after edge E(N_LIMBS).
- Throughput: at most one vector per N_LIMBS+1 cycles; the DONE→IDLE handshake cycle is never overlapped with acceptance.
- Backpressure: out_valid stays high and out_data constant until out_ready. in_ready stays 0 throughout ACCUM and DONE.
- If out_ready is already high when DONE is entered, the result transfers in the first DONE cycle.
- Reset mid-operation: any state returns to IDLE immediately and the partial result is discarded; no out_valid pulse follows.

## Configuration
- CRT_SIGNED_EN defined: centered-lift output.
  - x > ⌊Q/2⌋ gives out_data = x − Q, negative and sign-extended to OUT_W+1.
  - Otherwise out_data = x.
  - The comparison is done at the DONE register load and adds no latency.
- Undefined: out_data = {1'b0, x}, range [0, Q).
- With the macro undefined, no comparator or subtractor is instantiated.

## Structure
- Shared package (types.svh) holds:
  - q_BASIS (existing).
  - CRT constants Q, Q_HALF = ⌊Q/2⌋, CRT_QHAT[j], CRT_Y[j].
  - Typedefs for the residue vector and the OUT_W+1 result.
- CRT_QHAT, CRT_Y and Q_HALF are computed offline and stored as constants, never derived in RTL.
- One sub-module: modmul_reduce (a·b mod m, combinational, LIMB_W operands). It is used for the t computation, indexed by j through a mux over q_BASIS/CRT_Y.

## Test plan
The bench uses a test package with q_BASIS={3,5,7}, Q=105, QHAT={35,21,15}, Y={2,1,1}, LIMB_W=8.
1. Residues {1,2,3} (x=52), out_ready=1 → out_valid after 3 cycles, out_data=52 in both builds.
2. Residues {2,3,4} (x=53) → unsigned build 53; CRT_SIGNED_EN build −52.
3. Residues {2,4,6} (x=104) → unsigned 104, signed −1. Residues {0,0,0} → 0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data constant, in_ready=0, a second in_valid is ignored. Releasing out_ready gives one transfer, then in_ready=1 the next cycle.
5. Out-of-range residues {4,7,10} (≡{1,2,3}) → 52.
6. Assert rst_n low during ACCUM limb 1 → out_valid=0, in_ready=1 immediately, no result emitted. A fresh {1,2,3} afterwards returns 52.
